// File: rtl/reg_file_pkg.sv
// Shared register-file types and constants for the writeback arbiter slice.
// Provides widths, register count, typedefs and the arbiter state encoding.
package reg_file_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_DATA_WIDTH = 32;
  localparam int NUM_REGS       = 32;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;

  typedef enum logic [0:0] {
    RF_ARB_INIT = 1'b0,
    RF_ARB_ARB  = 1'b1
  } rf_arb_state_t;

endpackage

// File: rtl/reg_file_wr_arbiter_if.sv
// Writeback request bundle plus register-file write port.
// master: requester side (valid/reg/data out); slave: arbiter side.
interface reg_file_wr_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_reg;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          wr_en;
  logic [ADDR_WIDTH-1:0]         wr_reg;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic                          busy;

  modport master (
    output req_valid, req_reg, req_data,
    input  req_ready, wr_en, wr_reg, wr_data, busy
  );

  modport slave (
    input  req_valid, req_reg, req_data,
    output req_ready, wr_en, wr_reg, wr_data, busy
  );
endinterface

// File: rtl/reg_file_wr_arbiter_rr.sv
// Round-robin arbiter: one-hot grant scanning upward from ptr.
// Ports: clk, rst_n, req (per requester), advance (grant taken), gnt.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt
);
  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_REQ))
        sum = sum - (PW+1)'(NUM_REQ);
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        if (idx == PW'(NUM_REQ-1))
          ptr_nxt = '0;
        else
          ptr_nxt = idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (advance)
      ptr <= ptr_nxt;
  end
endmodule

// File: rtl/reg_file_wr_arbiter.sv
// Round-robin share of the register file write port; drops x0 writes.
// Ports: clk, rst_n, bus (slave). Option: RF_INIT_CLEAR_EN clears x1..x31.
module reg_file_wr_arbiter
  import reg_file_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
  input logic                  clk,
  input logic                  rst_n,
  reg_file_wr_arbiter_if.slave bus
);
  logic [NUM_REQ-1:0]    gnt;
  logic                  arb_en;
  logic                  xfer;
  logic                  keep;
  logic [ADDR_WIDTH-1:0] sel_reg;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_reg_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

`ifdef RF_INIT_CLEAR_EN
  localparam logic [0:0] ST_INIT = RF_ARB_INIT;
  localparam logic [0:0] ST_ARB  = RF_ARB_ARB;

  logic [0:0]          state;
  logic [ADDR_WIDTH:0] init_cnt;

  assign arb_en   = rst_n && (state == ST_ARB);
  assign bus.busy = (state == ST_INIT);
`else
  // Grants are masked while reset is low so ready drops asynchronously.
  assign arb_en   = rst_n;
  assign bus.busy = 1'b0;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.req_valid & {NUM_REQ{arb_en}}),
    .advance (xfer),
    .gnt     (gnt)
  );

  assign bus.req_ready = gnt;
  assign xfer          = |gnt;
  assign keep          = xfer && (sel_reg != '0);

  // Grant is one-hot, so OR-ing the masked lanes is a mux.
  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_reg  = sel_reg  | bus.req_reg[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = sel_data | bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
`ifdef RF_INIT_CLEAR_EN
      state     <= ST_INIT;
      init_cnt  <= (ADDR_WIDTH+1)'(1);
`endif
    end else
`ifdef RF_INIT_CLEAR_EN
    if (state == ST_INIT) begin
      // Count reaching NUM_REGS means x31 is already on the port.
      if (init_cnt == (ADDR_WIDTH+1)'(NUM_REGS)) begin
        state   <= ST_ARB;
        wr_en_q <= 1'b0;
      end else begin
        wr_en_q   <= 1'b1;
        wr_reg_q  <= init_cnt[ADDR_WIDTH-1:0];
        wr_data_q <= '0;
        init_cnt  <= init_cnt + 1'b1;
      end
    end else
`endif
    begin
      wr_en_q <= keep;
      if (keep) begin
        wr_reg_q  <= sel_reg;
        wr_data_q <= sel_data;
      end
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_reg  = wr_reg_q;
  assign bus.wr_data = wr_data_q;
endmodule
